// File: rtl/rv_mdu_issue.sv
// rv_mdu_issue -- issue/writeback controller for the rv32 M-extension
// multiply/divide datapath.
//
// Accepts one MUL/DIV-class request at a time and holds its opcode and
// operands stable toward the datapath. For a divide it pulses the start
// strobe for one cycle and then waits for the divider completion pulse. A
// multiply result is taken two edges after accept. The result leaves on a
// one-cycle register-file writeback port. This block owns the pipeline stall,
// x0 suppression, kill handling, a divider watchdog and a post-divide guard
// window.
//
// Parameters:
//   TIMEOUT  edges spent in DIV_BUSY without md_cmpl before err (default 31)
//   GUARD    idle edges after a divide before the next accept (default 2)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (accept when both are 1)
//   req_alu/rs1/rs2/rd         decoded op, operands and destination register
//   kill                       discard the in-flight result
//   md_alu, md_rrd1, md_rrd2   held op/operands toward the datapath (NOP idle)
//   md_rdy                     divider start strobe (one cycle)
//   md_rwdat, md_rwdatx        divide result, multiply result
//   md_cmpl                    divider completion pulse
//   wb_en, wb_rd, wb_dat       register-file writeback
//   busy                       pipeline stall
//   err                        one-cycle divider watchdog pulse
//
// Build option:
//   MDU_DIVZERO_FAST_EN  when defined, divide by zero and the signed overflow
//                        case (0x80000000 / -1) are resolved at accept
//                        without starting the divider.

package rv_mdu_pkg;
  typedef enum logic [3:0] {
    NOP, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_t;
endpackage

module rv_mdu_issue
  import rv_mdu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 31,
  parameter int unsigned GUARD   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  alu_t        req_alu,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        kill,
  output alu_t        md_alu,
  output logic [31:0] md_rrd1,
  output logic [31:0] md_rrd2,
  output logic        md_rdy,
  input  logic [31:0] md_rwdat,
  input  logic [31:0] md_rwdatx,
  input  logic        md_cmpl,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_dat,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MUL_WAIT = 3'd1;
  localparam logic [2:0] S_MUL_CAP  = 3'd2;
  localparam logic [2:0] S_DIV_BUSY = 3'd3;
  localparam logic [2:0] S_DIV_FIN  = 3'd4;

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned GD_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GD_W-1:0] GD_RELOAD = GD_W'(GUARD);

  logic [2:0]      state;
  logic [GD_W-1:0] guard;
  logic [WD_W-1:0] wd;
  logic [4:0]      rd_q;
  logic            kill_q;

  logic            accept;
  logic            req_is_div;
  logic            fast_hit;
  logic [31:0]     fast_dat;

  assign req_ready  = (state == S_IDLE) && (guard == '0) && !reset;
  assign busy       = (state != S_IDLE);
  assign accept     = req_valid && req_ready;
  assign req_is_div = (req_alu == DIV) || (req_alu == DIVU) ||
                      (req_alu == REM) || (req_alu == REMU);

`ifdef MDU_DIVZERO_FAST_EN
  // Results the divider would produce for the RISC-V special cases.
  always_comb begin
    fast_hit = 1'b0;
    fast_dat = '0;
    if (req_rs2 == '0) begin
      case (req_alu)
        DIV, DIVU: begin
          fast_hit = 1'b1;
          fast_dat = '1;
        end
        REM, REMU: begin
          fast_hit = 1'b1;
          fast_dat = req_rs1;
        end
        default: ;
      endcase
    end else if ((req_rs1 == 32'h8000_0000) && (req_rs2 == '1)) begin
      case (req_alu)
        DIV: begin
          fast_hit = 1'b1;
          fast_dat = 32'h8000_0000;
        end
        REM: begin
          fast_hit = 1'b1;
          fast_dat = '0;
        end
        default: ;
      endcase
    end
  end
`else
  assign fast_hit = 1'b0;
  assign fast_dat = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      guard   <= '0;
      wd      <= '0;
      rd_q    <= '0;
      kill_q  <= 1'b0;
      md_alu  <= NOP;
      md_rrd1 <= '0;
      md_rrd2 <= '0;
      md_rdy  <= 1'b0;
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_dat  <= '0;
      err     <= 1'b0;
    end else begin
      md_rdy <= 1'b0;
      wb_en  <= 1'b0;
      err    <= 1'b0;

      if (guard != '0) guard <= guard - 1'b1;

      // The divider cannot be aborted, so kill only marks the result dead.
      if ((state != S_IDLE) && kill) kill_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (accept) begin
            md_rrd1 <= req_rs1;
            md_rrd2 <= req_rs2;
            rd_q    <= req_rd;
            kill_q  <= 1'b0;
            wd      <= '0;
            if (fast_hit) begin
              // Resolved here; md_alu stays NOP and no guard is needed.
              wb_en  <= (req_rd != '0);
              wb_rd  <= req_rd;
              wb_dat <= fast_dat;
            end else if (req_is_div) begin
              md_alu <= req_alu;
              md_rdy <= 1'b1;
              state  <= S_DIV_BUSY;
            end else begin
              md_alu <= req_alu;
              state  <= S_MUL_WAIT;
            end
          end
        end

        S_MUL_WAIT: state <= S_MUL_CAP;

        S_MUL_CAP: begin
          wb_dat <= md_rwdatx;
          wb_rd  <= rd_q;
          wb_en  <= (rd_q != '0) && !(kill_q || kill);
          md_alu <= NOP;
          state  <= S_IDLE;
        end

        S_DIV_BUSY: begin
          if (md_cmpl) begin
            state <= S_DIV_FIN;
          end else if (wd == WD_LAST) begin
            err    <= 1'b1;
            guard  <= GD_RELOAD;
            md_alu <= NOP;
            state  <= S_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        S_DIV_FIN: begin
          wb_dat <= md_rwdat;
          wb_rd  <= rd_q;
          wb_en  <= (rd_q != '0) && !(kill_q || kill);
          guard  <= GD_RELOAD;
          md_alu <= NOP;
          state  <= S_IDLE;
        end

        default: begin
          md_alu <= NOP;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mdu_issue.sv
// Testbench for rv_mdu_issue. Expected per-cycle outputs come from a timeline
// built from each transaction's arithmetic result and its documented latency.
module tb_rv_mdu_issue;
  import rv_mdu_pkg::*;

  localparam int TO = 31;
  localparam int GD = 2;
  localparam int NC = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  alu_t        req_alu;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        kill;
  alu_t        md_alu;
  logic [31:0] md_rrd1, md_rrd2;
  logic        md_rdy;
  logic [31:0] md_rwdat, md_rwdatx;
  logic        md_cmpl;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_dat;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Expected timeline, indexed by cycle number (cycle k follows edge k).
  bit          e_busy  [0:NC-1];
  bit          e_ready [0:NC-1];
  bit          e_mdrdy [0:NC-1];
  bit          e_err   [0:NC-1];
  bit          e_wben  [0:NC-1];
  bit          e_wbv   [0:NC-1];
  logic [4:0]  e_rd    [0:NC-1];
  logic [31:0] e_dat   [0:NC-1];
  alu_t        e_alu   [0:NC-1];
  logic [31:0] e_a     [0:NC-1];
  logic [31:0] e_b     [0:NC-1];

  rv_mdu_issue #(.TIMEOUT(TO), .GUARD(GD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_alu(req_alu),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .kill(kill),
    .md_alu(md_alu), .md_rrd1(md_rrd1), .md_rrd2(md_rrd2), .md_rdy(md_rdy),
    .md_rwdat(md_rwdat), .md_rwdatx(md_rwdatx), .md_cmpl(md_cmpl),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_dat(wb_dat), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RV32M arithmetic, including the divide-by-zero and overflow results.
  function automatic logic [31:0] mdu_model(input alu_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [63:0] sa, sb, ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      MUL:    begin p = ua * ub; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:    if (b == 0) return 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
              else return $signed(a) / $signed(b);
      DIVU:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      REM:    if (b == 0) return a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
              else return $signed(a) % $signed(b);
      REMU:   if (b == 0) return a; else return a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_div(input alu_t op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

  // Datapath stand-in: both results follow the held op and operands.
  assign md_rwdatx = is_div(md_alu) ? 32'h0 : mdu_model(md_alu, md_rrd1, md_rrd2);
  assign md_rwdat  = is_div(md_alu) ? mdu_model(md_alu, md_rrd1, md_rrd2) : 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("busy", busy, e_busy[cyc]);
      chk("req_ready", req_ready, e_ready[cyc]);
      chk("md_rdy", md_rdy, e_mdrdy[cyc]);
      chk("err", err, e_err[cyc]);
      chk("wb_en", wb_en, e_wben[cyc]);
      if (e_wbv[cyc]) begin
        chk("wb_rd", wb_rd, e_rd[cyc]);
        chk("wb_dat", wb_dat, e_dat[cyc]);
      end
      if (e_busy[cyc]) begin
        chk("md_alu", md_alu, e_alu[cyc]);
        chk("md_rrd1", md_rrd1, e_a[cyc]);
        chk("md_rrd2", md_rrd2, e_b[cyc]);
      end else begin
        chk("md_alu_idle", md_alu, NOP);
      end
    end
  end

  // Present a request and hold it until the model says it is accepted.
  task automatic present(input alu_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int c);
    int n;
    req_valid = 1'b1; req_alu = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    n = 0;
    while (!e_ready[cyc] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      errors++; checks++;
      $display("FAIL accept_wait cyc=%0d got=no_accept expected=accept", cyc);
    end
    c = cyc;
  endtask

  task automatic mark_busy(input int from, input int to, input alu_t op,
                           input logic [31:0] a, input logic [31:0] b);
    for (int i = from; i <= to; i++) begin
      e_busy[i] = 1'b1; e_ready[i] = 1'b0;
      e_alu[i] = op; e_a[i] = a; e_b[i] = b;
    end
  endtask

  task automatic mark_wb(input int at, input bit en, input logic [4:0] rd, input logic [31:0] d);
    e_wben[at] = en; e_wbv[at] = 1'b1; e_rd[at] = rd; e_dat[at] = d;
  endtask

  // d: md_cmpl sampled on edge (accept+d), 0 = never. k: kill sampled on
  // edge (accept+k); k<0 asserts kill on the accept edge only.
  task automatic run(input alu_t op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input int d, input int k);
    int c, fin;
    logic [31:0] r;
    bit fast, killed;
    r = mdu_model(op, a, b);
    fast = 1'b0;
`ifdef MDU_DIVZERO_FAST_EN
    fast = is_div(op) && ((b == 0) ||
           ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`endif
    if (k < 0) kill = 1'b1;
    present(op, a, b, rd, c);
    killed = (k > 0);
    if (fast) begin
      mark_wb(c + 1, rd != 0, rd, r);
      fin = c + 2;
    end else if (!is_div(op)) begin
      mark_busy(c + 1, c + 2, op, a, b);
      mark_wb(c + 3, (rd != 0) && !killed, rd, r);
      fin = c + 4;
    end else if (d > 0) begin
      mark_busy(c + 1, c + 1 + d, op, a, b);
      e_mdrdy[c + 1] = 1'b1;
      for (int i = c + 2 + d; i <= c + 1 + d + GD; i++) e_ready[i] = 1'b0;
      mark_wb(c + 2 + d, (rd != 0) && !killed, rd, r);
      fin = c + 3 + d + GD;
    end else begin
      mark_busy(c + 1, c + TO, op, a, b);
      e_mdrdy[c + 1] = 1'b1;
      e_err[c + TO + 1] = 1'b1;
      for (int i = c + TO + 1; i <= c + TO + GD; i++) e_ready[i] = 1'b0;
      fin = c + TO + GD + 1;
    end
    @(negedge clk);
    req_valid = 1'b0;
    kill = 1'b0;
    while (cyc < fin) begin
      md_cmpl = (d > 0) && (cyc == c + d);
      kill    = (k > 0) && (cyc == c + k);
      @(negedge clk);
    end
    md_cmpl = 1'b0;
    kill = 1'b0;
  endtask

  // Divide interrupted by reset after five busy cycles.
  task automatic run_reset_mid();
    int c;
    present(DIVU, 32'd50, 32'd5, 5'd4, c);
    mark_busy(c + 1, c + 5, DIVU, 32'd50, 32'd5);
    e_mdrdy[c + 1] = 1'b1;
    e_ready[c + 6] = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < c + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      e_busy[i] = 0; e_ready[i] = 1; e_mdrdy[i] = 0; e_err[i] = 0;
      e_wben[i] = 0; e_wbv[i] = 0; e_rd[i] = '0; e_dat[i] = '0;
      e_alu[i] = NOP; e_a[i] = '0; e_b[i] = '0;
    end
    reset = 1'b1; req_valid = 1'b0; req_alu = NOP; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; kill = 1'b0; md_cmpl = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_md_alu", md_alu, NOP);
    chk("rst_md_rrd1", md_rrd1, 0);
    chk("rst_md_rrd2", md_rrd2, 0);
    chk("rst_md_rdy", md_rdy, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_dat", wb_dat, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);

    run(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, 0);
    chk("mulhu_lit_dat", wb_dat, 32'hFFFF_FFFE);
    chk("mulhu_lit_rd", wb_rd, 5);

    run(DIVU, 32'd100, 32'd7, 5'd3, 4, 0);
    chk("divu_lit_dat", wb_dat, 14);

    run(REM, 32'hFFFF_FFF9, 32'd2, 5'd0, 3, 0);
    chk("rem_lit_dat", wb_dat, 32'hFFFF_FFFF);

    run(DIV, 32'd1000, 32'hFFFF_FFFD, 5'd7, 5, 2);
    chk("div_kill_lit_dat", wb_dat, 32'hFFFF_FEB3);
    run(MUL, 32'hFFFF_FFFF, 32'd3, 5'd9, 0, 0);
    chk("mul_after_kill_lit", wb_dat, 32'hFFFF_FFFD);

    run(MULH, 32'h8000_0000, 32'h8000_0000, 5'd10, 0, 0);
    chk("mulh_lit", wb_dat, 32'h4000_0000);
    run(MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd11, 0, 0);
    chk("mulhsu_lit", wb_dat, 32'hFFFF_FFFF);

    // Completion pulse while idle must do nothing.
    md_cmpl = 1'b1;
    @(negedge clk);
    md_cmpl = 1'b0;
    repeat (3) @(negedge clk);

    run(DIV, 32'd5, 32'd0, 5'd6, 2, 0);
    chk("div0_lit", wb_dat, 32'hFFFF_FFFF);
    run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1, 0);
    chk("rem_ovf_lit", wb_dat, 32'h0);

    run(DIVU, 32'd9, 32'd2, 5'd2, 0, 0);
    run(DIVU, 32'd9, 32'd2, 5'd2, 1, 0);
    chk("divu_fast_cmpl_lit", wb_dat, 4);

    run_reset_mid();
    chk("rst_mid_wb_dat", wb_dat, 0);
    chk("rst_mid_wb_rd", wb_rd, 0);

    run(MUL, 32'd6, 32'd7, 5'd1, 0, -1);
    chk("mul_kill_on_accept_lit", wb_dat, 42);

    repeat (3) @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_mdu_issue.md
# rv_mdu_issue

Issue/writeback controller for the M-extension multiply/divide unit in the rv32 execute stage. It accepts one decoded MUL/DIV-class request at a time, holds operands stable toward the mul/div datapath, pulses its start strobe, and waits for the 2-cycle multiply result or the divider completion pulse. It then returns the result on a one-cycle register-file writeback port. Pipeline stall (`busy`), x0 suppression, kill handling and a divider watchdog are owned here, not in the datapath.

## Interface
- `TIMEOUT`, default 31: max edges in DIV_BUSY without `md_cmpl` before `err`.
- `GUARD`, default 2: idle edges enforced after a divide writeback before the next request is accepted.
- `clk` in 1: clock.
- `reset` in 1: reset; one clock; reset is synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on an edge where both are 1.
- `req_alu` in alu_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `req_rs1`, `req_rs2` in 32: operands.
- `req_rd` in 5: destination register.
- `kill` in 1: discard the in-flight result.
- `md_alu` out alu_t: held op toward the datapath; `NOP` when idle.
- `md_rrd1`, `md_rrd2` out 32: held operands.
- `md_rdy` out 1: divider start strobe.
- `md_rwdat` in 32: divide result.
- `md_rwdatx` in 32: multiply result.
- `md_cmpl` in 1: divider completion pulse.
- `wb_en` out 1, `wb_rd` out 5, `wb_dat` out 32: writeback.
- `busy` out 1: stall to the pipeline.
- `err` out 1: one-cycle watchdog pulse.

## Operation
- States: IDLE, MUL_WAIT, MUL_CAP, DIV_BUSY, DIV_FIN.
- IDLE:
  - `req_ready` = (state==IDLE) && guard==0 && !reset.
  - On accept, `req_alu`, `req_rs1`, `req_rs2` and `req_rd` are registered into `md_alu`, `md_rrd1`, `md_rrd2` and `rd_q`.
  - `kill_q` is cleared on accept.
- MUL-class: IDLE→MUL_WAIT→MUL_CAP. In MUL_CAP, `md_rwdatx` is sampled into `wb_dat`. `wb_en` is asserted, then the block returns to IDLE.
- DIV-class: accept→DIV_BUSY. `md_rdy` is high for exactly the first DIV_BUSY cycle.
  - `md_alu` and `md_rrd*` are held unchanged through DIV_FIN, because the divider selects its result from `md_alu` every cycle.
- DIV_BUSY: the edge where `md_cmpl` is sampled 1 moves to DIV_FIN.
- DIV_FIN: one cycle. At its closing edge, `md_rwdat` is sampled into `wb_dat`, `wb_en` is asserted, guard is loaded with `GUARD`, and the block returns to IDLE.
- Guard counter decrements each edge while nonzero. It exists because the divider returns to idle only after its completion pulse; a start during that window is lost.
- Writeback suppression: `wb_en`=0 if `rd_q`==0 or `kill_q`=1. `wb_rd` and `wb_dat` are still updated.
- `kill`:
  - Sampled in any non-IDLE state, it sets `kill_q`.
  - The divider cannot be aborted, so DIV_BUSY still waits for `md_cmpl`.
  - `kill` in IDLE is ignored.
  - `kill` on the accept edge does not affect the new request.
- Watchdog: a counter runs in DIV_BUSY. At `TIMEOUT` it pulses `err`, moves to IDLE with no writeback, and loads guard with `GUARD`.
- `busy` = state!=IDLE.
- `md_alu` returns to `NOP` in IDLE so the multiply result mux outputs 0.

## Timing
- Reset values: state IDLE, `req_ready`=0 during reset, `md_alu`=NOP, `md_rrd*`=0, `md_rdy`=0, `wb_en`=0, `wb_rd`=0, `wb_dat`=0, `busy`=0, `err`=0, guard=0, `kill_q`=0.
- All outputs are registered except `req_ready` and `busy`, which are decoded from state.
- MUL: accept at edge E0; the datapath samples at E1; `wb_en` is high during cycle (E2,E3). `busy` is high for 2 cycles.
- DIV: `md_rdy` is high during (E0,E1). `wb_en` is high in the cycle after DIV_FIN, 2 edges after `md_cmpl` is first sampled high.
- Reset mid-operation returns to IDLE on the next edge with no writeback. The datapath is reset from the same `reset`, inverted at the top level.
- `md_cmpl` seen outside DIV_BUSY is ignored.

## Configuration
- `MDU_DIVZERO_FAST_EN` defined: IDLE decodes special divides and resolves them without starting the divider. `wb_en` is high in the cycle after the accept edge, and guard is not loaded.
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - rs1=0x80000000 with rs2=0xFFFFFFFF on DIV/REM: DIV gives 0x80000000, REM gives 0.
- Undefined: every divide uses the divider, and its raw result is written back.

## Test plan
- MULHU with 0xFFFFFFFF, 0xFFFFFFFF, rd=5 -> `wb_en` in (E2,E3), `wb_rd`=5, `wb_dat`=0xFFFFFFFE; `busy` high for 2 cycles.
- DIVU 100/7, rd=3 -> one `md_rdy` pulse; `wb_dat`=14 two edges after `md_cmpl`; `req_ready` stays 0 for `GUARD` edges after.
- REM −7/2 with rd=0 -> `wb_dat`=0xFFFFFFFF, `wb_en`=0.
- DIV issued, `kill` mid-busy -> no `wb_en`; back-to-back MUL after the guard writes back normally.
- `md_cmpl` held 0 -> `err` pulses after 31 edges, state IDLE, no `wb_en`.
- `MDU_DIVZERO_FAST_EN`: DIV 5/0 -> `wb_dat`=0xFFFFFFFF one edge after accept, `md_rdy` never asserted. Without the macro, the same request uses the divider.
